// File: rtl/fft8_in_loader_pkg.sv
// Shared definitions for the 8-point FFT input loader and output unloader:
// frame geometry, bit-reverse lane mapping and packed-bus lane slicing.
package fft8_in_loader_pkg;

    localparam int N     = 8;
    localparam int LOG2N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } fill_state_e;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Bit offset of a lane inside a packed N*w bus.
    function automatic int unsigned lane_lsb(input logic [LOG2N-1:0] lane, input int unsigned w);
        return w * {29'd0, lane};
    endfunction

endpackage

// File: rtl/fft8_in_loader_if.sv
// Sample-stream and parallel-frame signals of the FFT input loader.
// master = the loader itself, slave = the surrounding environment.
interface fft8_in_loader_if #(
    parameter int W = 16
);
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_re;
    logic [W-1:0]   s_im;
    logic           s_last;
    logic           f_valid;
    logic           f_ready;
    logic [8*W-1:0] x_re;
    logic [8*W-1:0] x_im;
    logic           frame_err;
    logic [7:0]     frame_cnt;

    modport master (
        input  s_valid, s_re, s_im, s_last, f_ready,
        output s_ready, f_valid, x_re, x_im, frame_err, frame_cnt
    );

    modport slave (
        output s_valid, s_re, s_im, s_last, f_ready,
        input  s_ready, f_valid, x_re, x_im, frame_err, frame_cnt
    );
endinterface

// File: rtl/fft8_frame_buf.sv
// 8-lane complex fill buffer: single-lane write port, full-frame parallel read.
module fft8_frame_buf
    import fft8_in_loader_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [LOG2N-1:0] waddr_i,
    input  logic [W-1:0]     wre_i,
    input  logic [W-1:0]     wim_i,
    output logic [N*W-1:0]   rd_re_o,
    output logic [N*W-1:0]   rd_im_o
);

    logic [W-1:0] re_q [N];
    logic [W-1:0] im_q [N];

    // Lane storage, cleared on reset so a discarded frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < N; j++) begin
                re_q[j] <= '0;
                im_q[j] <= '0;
            end
        end else if (we_i) begin
            re_q[waddr_i] <= wre_i;
            im_q[waddr_i] <= wim_i;
        end
    end

    // Pack all lanes onto the parallel read buses.
    always_comb begin
        rd_re_o = '0;
        rd_im_o = '0;
        for (int j = 0; j < N; j++) begin
            rd_re_o[lane_lsb(LOG2N'(j), W) +: W] = re_q[j];
            rd_im_o[lane_lsb(LOG2N'(j), W) +: W] = im_q[j];
        end
    end

endmodule

// File: rtl/fft8_in_loader.sv
// FFT input loader: groups a serial complex stream into 8-sample frames
// (bit-reversed or natural lane order) and double-buffers them onto an 8-lane bus.
module fft8_in_loader
    import fft8_in_loader_pkg::*;
#(
    parameter int W      = 16,
    parameter int BITREV = 1
) (
    input logic               clk,
    input logic               rst,
    fft8_in_loader_if.master  bus
);

    localparam logic [LOG2N-1:0] LAST_LANE = (BITREV != 0) ? bitrev3(3'd7) : 3'd7;

    function automatic logic [LOG2N-1:0] lane_of(input logic [LOG2N-1:0] k);
        if (BITREV != 0) begin
            return bitrev3(k);
        end else begin
            return k;
        end
    endfunction

    fill_state_e      state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             f_valid_q, f_valid_d;
    logic             err_q, err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [N*W-1:0]   x_re_q, x_im_q;

    logic             accept_s;
    logic             handoff_s;
    logic             hold_free_s;
    logic             buf_we_s;
    logic [LOG2N-1:0] buf_waddr_s;
    logic             load_direct_s;
    logic             load_buf_s;
    logic [N*W-1:0]   buf_re_s, buf_im_s;
    logic [N*W-1:0]   frame_re_s, frame_im_s;

    assign accept_s    = bus.s_valid & s_ready_q;
    assign handoff_s   = f_valid_q & bus.f_ready;
    assign hold_free_s = ~f_valid_q | bus.f_ready;
    assign buf_waddr_s = lane_of(cnt_q);

    fft8_frame_buf #(
        .W (W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (buf_we_s),
        .waddr_i (buf_waddr_s),
        .wre_i   (bus.s_re),
        .wim_i   (bus.s_im),
        .rd_re_o (buf_re_s),
        .rd_im_o (buf_im_s)
    );

    // Fill FSM: sample counting, framing errors and holding-register loads.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        f_valid_d     = f_valid_q & ~bus.f_ready;
        err_d         = 1'b0;
        buf_we_s      = 1'b0;
        load_direct_s = 1'b0;
        load_buf_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FILL;
            end
            ST_FILL: begin
                if (accept_s) begin
                    if (cnt_q != 3'd7) begin
                        if (bus.s_last) begin
                            err_d = 1'b1;
                            cnt_d = 3'd0;
                        end else begin
                            buf_we_s = 1'b1;
                            cnt_d    = cnt_q + 3'd1;
                        end
                    end else begin
                        // Eighth sample always closes the frame; a missing last is only flagged.
                        err_d = ~bus.s_last;
                        cnt_d = 3'd0;
                        if (hold_free_s) begin
                            load_direct_s = 1'b1;
                            f_valid_d     = 1'b1;
                        end else begin
                            buf_we_s = 1'b1;
                            state_d  = ST_FULL;
                        end
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_FULL: begin
                if (handoff_s) begin
                    load_buf_s = 1'b1;
                    f_valid_d  = 1'b1;
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Handshake side-effects that do not depend on the fill state.
    always_comb begin
        s_ready_d = (state_d == ST_FILL);
        if (handoff_s) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame to load: buffer contents, with the in-flight eighth sample bypassed into its lane.
    always_comb begin
        frame_re_s = '0;
        frame_im_s = '0;
        for (int j = 0; j < N; j++) begin
            if (load_direct_s && (LOG2N'(j) == LAST_LANE)) begin
                frame_re_s[lane_lsb(LOG2N'(j), W) +: W] = bus.s_re;
                frame_im_s[lane_lsb(LOG2N'(j), W) +: W] = bus.s_im;
            end else begin
                frame_re_s[lane_lsb(LOG2N'(j), W) +: W] = buf_re_s[lane_lsb(LOG2N'(j), W) +: W];
                frame_im_s[lane_lsb(LOG2N'(j), W) +: W] = buf_im_s[lane_lsb(LOG2N'(j), W) +: W];
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            s_ready_q   <= 1'b0;
            f_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_ready_q   <= s_ready_d;
            f_valid_q   <= f_valid_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Holding register; only written when the downstream slot is free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_re_q <= '0;
            x_im_q <= '0;
        end else if (load_direct_s || load_buf_s) begin
            x_re_q <= frame_re_s;
            x_im_q <= frame_im_s;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.f_valid   = f_valid_q;
    assign bus.x_re      = x_re_q;
    assign bus.x_im      = x_im_q;
    assign bus.frame_err = err_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft8_in_loader.sv
// Directed bench for fft8_in_loader: a bit-reversed and a natural-order instance
// share one stimulus stream; expected frames are built from hand-chosen sample ramps.
module tb_fft8_in_loader;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft8_in_loader_if #(.W(W)) ib ();
    fft8_in_loader_if #(.W(W)) nb ();

    fft8_in_loader #(.W(W), .BITREV(1)) dut_br (.clk(clk), .rst(rst), .bus(ib));
    fft8_in_loader #(.W(W), .BITREV(0)) dut_nat (.clk(clk), .rst(rst), .bus(nb));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int re, input int im, input logic last);
        ib.s_valid = v;  ib.s_re = W'(re);  ib.s_im = W'(im);  ib.s_last = last;
        nb.s_valid = v;  nb.s_re = W'(re);  nb.s_im = W'(im);  nb.s_last = last;
    endtask

    task automatic set_ready(input logic r);
        ib.f_ready = r;
        nb.f_ready = r;
    endtask

    task automatic send(input int re, input int im, input logic last);
        bit done;
        done = 1'b0;
        drive(1'b1, re, im, last);
        for (int n = 0; n < 64 && !done; n++) begin
            done = (ib.s_ready === 1'b1);
            tick();
        end
        if (!done) chk_bit("accept_timeout", done, 1'b1);
        drive(1'b0, 0, 0, 1'b0);
    endtask

    // Sample i of the run has re = re0 + i, im = im0 - i; s_last on index last_at.
    task automatic send_seq(input int re0, input int im0, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            send(re0 + i, im0 - i, (i == last_at));
        end
    endtask

    function automatic logic [8*W-1:0] exp_bus(input int base, input int step, input bit br);
        logic [8*W-1:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) begin
            int s;
            s = br ? br_tab[j] : j;
            v[j*W +: W] = W'(base + s * step);
        end
        return v;
    endfunction

    initial begin
        drive(1'b0, 0, 0, 1'b0);
        set_ready(1'b0);
        rst = 1'b0;
        tick();
        tick();
        chk_bit("rst_s_ready", ib.s_ready, 1'b0);
        chk_bit("rst_f_valid", ib.f_valid, 1'b0);
        chk("rst_x_re", ib.x_re, '0);
        chk("rst_x_im", ib.x_im, '0);
        chk_bit("rst_frame_err", ib.frame_err, 1'b0);
        chk("rst_frame_cnt", 128'(ib.frame_cnt), 128'd0);
        rst = 1'b1;
        tick();
        chk_bit("rel_s_ready", ib.s_ready, 1'b1);

        // Reset in the middle of a frame, then a clean frame 1..8
        set_ready(1'b1);
        send_seq(50, 0, 3, -1);
        rst = 1'b0;
        #1;
        chk_bit("midrst_s_ready", ib.s_ready, 1'b0);
        chk_bit("midrst_f_valid", ib.f_valid, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk_bit("midrst_rel_ready", ib.s_ready, 1'b1);
        chk_bit("midrst_no_frame", ib.f_valid, 1'b0);
        send_seq(1, -1, 7, 7);
        chk_bit("pre8_f_valid", ib.f_valid, 1'b0);
        send(8, -8, 1'b1);
        chk("br_re", ib.x_re, exp_bus(1, 1, 1'b1));
        chk("br_im", ib.x_im, exp_bus(-1, -1, 1'b1));
        chk_bit("br_f_valid", ib.f_valid, 1'b1);
        chk_bit("br_frame_err", ib.frame_err, 1'b0);
        chk("br_cnt_before", 128'(ib.frame_cnt), 128'd0);
        tick();
        chk_bit("br_pulse_end", ib.f_valid, 1'b0);
        chk("br_cnt_after", 128'(ib.frame_cnt), 128'd1);

        // Natural order on the BITREV=0 instance
        send_seq(100, 0, 8, 7);
        chk("nat_re", nb.x_re, exp_bus(100, 1, 1'b0));
        chk("nat_im", nb.x_im, exp_bus(0, -1, 1'b0));
        chk("nat_br_re", ib.x_re, exp_bus(100, 1, 1'b1));
        tick();
        chk("nat_cnt", 128'(ib.frame_cnt), 128'd2);

        // Backpressure: frame A held, frame B fills, stream stalls
        set_ready(1'b0);
        for (int i = 0; i < 16; i++) begin
            send(200 + i, -200 - i, (i % 8) == 7);
        end
        chk_bit("bp_s_ready_low", ib.s_ready, 1'b0);
        chk_bit("bp_f_valid", ib.f_valid, 1'b1);
        chk("bp_hold_a", ib.x_re, exp_bus(200, 1, 1'b1));
        drive(1'b1, 216, -216, 1'b0);
        repeat (3) tick();
        chk("bp_stable_a_re", ib.x_re, exp_bus(200, 1, 1'b1));
        chk("bp_stable_a_im", ib.x_im, exp_bus(-200, -1, 1'b1));
        chk_bit("bp_still_blocked", ib.s_ready, 1'b0);
        chk("bp_cnt_hold", 128'(ib.frame_cnt), 128'd2);
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        chk("bp_b_re", ib.x_re, exp_bus(208, 1, 1'b1));
        chk("bp_b_im", ib.x_im, exp_bus(-208, -1, 1'b1));
        chk_bit("bp_b_valid", ib.f_valid, 1'b1);
        chk_bit("bp_s_ready_back", ib.s_ready, 1'b1);
        chk("bp_cnt_b", 128'(ib.frame_cnt), 128'd3);
        send_seq(216, -216, 8, 7);
        chk_bit("bp_c_full", ib.s_ready, 1'b0);
        chk("bp_b_kept", ib.x_re, exp_bus(208, 1, 1'b1));
        set_ready(1'b1);
        tick();
        chk("bp_c_re", ib.x_re, exp_bus(216, 1, 1'b1));
        chk("bp_c_im", ib.x_im, exp_bus(-216, -1, 1'b1));
        chk("bp_cnt_c", 128'(ib.frame_cnt), 128'd4);
        tick();
        chk_bit("bp_drained", ib.f_valid, 1'b0);
        chk("bp_cnt_end", 128'(ib.frame_cnt), 128'd5);

        // Early last on the 4th sample
        send_seq(300, -300, 4, 3);
        chk_bit("el_err", ib.frame_err, 1'b1);
        chk_bit("el_no_frame", ib.f_valid, 1'b0);
        send_seq(310, -310, 8, 7);
        chk("el_next_re", ib.x_re, exp_bus(310, 1, 1'b1));
        chk("el_next_im", ib.x_im, exp_bus(-310, -1, 1'b1));
        chk_bit("el_next_valid", ib.f_valid, 1'b1);
        chk_bit("el_next_err", ib.frame_err, 1'b0);
        tick();
        chk("el_cnt", 128'(ib.frame_cnt), 128'd6);

        // Missing last
        send_seq(400, -400, 7, -1);
        chk_bit("ml_err_pre", ib.frame_err, 1'b0);
        send(407, -407, 1'b0);
        chk("ml_re", ib.x_re, exp_bus(400, 1, 1'b1));
        chk_bit("ml_valid", ib.f_valid, 1'b1);
        chk_bit("ml_err", ib.frame_err, 1'b1);
        tick();
        chk_bit("ml_err_once", ib.frame_err, 1'b0);
        chk("ml_cnt", 128'(ib.frame_cnt), 128'd7);

        // New frame completes in the same cycle the old one is taken
        set_ready(1'b0);
        send_seq(500, -500, 8, 7);
        chk("sim_d_re", ib.x_re, exp_bus(500, 1, 1'b1));
        send_seq(510, -510, 7, -1);
        set_ready(1'b1);
        send(517, -517, 1'b1);
        chk_bit("sim_no_gap", ib.f_valid, 1'b1);
        chk("sim_e_re", ib.x_re, exp_bus(510, 1, 1'b1));
        chk("sim_e_im", ib.x_im, exp_bus(-510, -1, 1'b1));
        chk("sim_cnt", 128'(ib.frame_cnt), 128'd8);
        tick();
        chk_bit("sim_drained", ib.f_valid, 1'b0);
        chk("sim_cnt_end", 128'(ib.frame_cnt), 128'd9);

        // frame_cnt wraps after 256 handoffs
        for (int f = 0; f < 247; f++) begin
            send_seq(600 + f, 0, 8, 7);
        end
        chk("wrap_255", 128'(ib.frame_cnt), 128'd255);
        chk_bit("wrap_valid", ib.f_valid, 1'b1);
        tick();
        chk("wrap_0", 128'(ib.frame_cnt), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
